// File: rtl/common_pkg.sv
// common: cbus request/response types and the MLEN/MSIZE/AXI_BURST encodings shared
// by the cache-side blocks (caches, arbiters, cbus-to-AXI bridge).
package common;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;
  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;
  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'd0;
  localparam axi_burst_t AXI_BURST_INCR  = 2'd1;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'd2;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  // Grant index wide enough for the largest arbiter; narrower arbiters truncate.
  localparam int ARB_MAX_INPUTS = 8;
  typedef logic [$clog2(ARB_MAX_INPUTS)-1:0] arb_idx_t;
endpackage

// File: rtl/cbus_arbiter_rr_priority_encoder.sv
// rr_priority_encoder: first set bit of valid scanning from ptr upward, modulo N.
module rr_priority_encoder #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  always_comb begin
    dbl = {valid, valid} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int k = N-1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    found = |valid;
    idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter granting one cbus master a whole burst (until
// ready && last) and routing the memory-side response back to that master only.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int IW = $clog2(NUM_INPUTS);
  typedef logic [IW-1:0] idx_t;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  idx_t sel, ptr, win;
  logic found;
  logic [NUM_INPUTS-1:0] valid;
  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) valid[i] = ireqs[i].valid;
  end
  rr_priority_encoder #(.N(NUM_INPUTS)) u_enc (
    .valid(valid),
    .ptr(ptr),
    .found(found),
    .idx(win)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        sel <= win;
        state <= BUSY;
      end
    end else if (oresp.ready && oresp.last) begin
      state <= IDLE;
      ptr <= sel == idx_t'(NUM_INPUTS-1) ? '0 : sel + idx_t'(1);
    end
  end
  // Request and response paths are pure muxes so beats see no added latency.
  always_comb begin
    oreq = state == BUSY ? ireqs[sel] : '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = (state == BUSY && sel == idx_t'(i)) ? oresp : '0;
  end
  // A granted master must keep valid up to and including its ready && last beat.
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    state == BUSY |-> ireqs[sel].valid);
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed test-plan scenarios plus randomized traffic, every cycle
// compared against a burst-level round-robin reference model.
module tb_cbus_arbiter;
  import common::*;
  localparam int N = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  cbus_req_t  ireqs [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk(clk),
    .reset(reset),
    .ireqs(ireqs),
    .iresps(iresps),
    .oreq(oreq),
    .oresp(oresp)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int cyc = 0, m_owner = 0, m_ptr = 0, m_beat = 0;
  bit m_busy = 0, armed = 0, rnd_mem = 0, prev_v = 0;
  int rerq_pct = 0, raise_pct = 0;
  int left [N];
  int glog [$], gcyc [$], dcyc [$];
  int d_beats = 0, d_lasts = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t mk(logic w, logic [31:0] a, mlen_t l, logic [7:0] s);
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1;
    r.is_write = w;
    r.size = MSIZE8;
    r.addr = a;
    r.strobe = s;
    r.data = {$urandom, $urandom};
    r.len = l;
    r.burst = l == MLEN1 ? AXI_BURST_INCR : AXI_BURST_WRAP;
    return r;
  endfunction

  function automatic cbus_req_t rnd_req(int i);
    mlen_t l;
    l = $urandom_range(0, 7) == 0 ? MLEN16 : mlen_t'($urandom_range(0, 3));
    return mk(1'($urandom_range(0, 1)), {4'(i), 28'($urandom)}, l, 8'($urandom));
  endfunction

  function automatic bit any_valid();
    bit v = 0;
    for (int i = 0; i < N; i++) v |= ireqs[i].valid;
    return v;
  endfunction

  // One clock: memory drive, compare, edge, then model and master updates.
  task automatic step();
    int best, o, g;
    bit done;
    oresp.data = {$urandom, $urandom};
    if (rnd_mem) begin
      oresp.ready = $urandom_range(0, 3) != 0;
      oresp.last = (m_busy && oresp.ready) ? (m_beat == int'(ireqs[m_owner].len))
                                           : 1'($urandom_range(0, 1));
    end else begin
      oresp.ready = m_busy;
      oresp.last = m_busy && m_beat == int'(ireqs[m_owner].len);
    end
    #1;
    if (armed) begin
      check("oreq", 128'(oreq), m_busy ? 128'(ireqs[m_owner]) : 128'(0));
      for (int i = 0; i < N; i++)
        check($sformatf("iresp%0d", i), 128'(iresps[i]),
              (m_busy && m_owner == i) ? 128'(oresp) : 128'(0));
    end
    if (oreq.valid && !prev_v) begin
      g = -1;
      for (int i = N-1; i >= 0; i--) if (oreq == ireqs[i]) g = i;
      glog.push_back(g);
      gcyc.push_back(cyc);
    end
    prev_v = oreq.valid;
    if (iresps[1].ready) d_beats++;
    if (iresps[1].ready && iresps[1].last) d_lasts++;
    @(posedge clk);
    #1;
    cyc++;
    o = m_owner;
    done = m_busy && oresp.ready && oresp.last;
    if (reset) begin
      armed = 1;
      m_busy = 0;
      m_owner = 0;
      m_ptr = 0;
      m_beat = 0;
    end else if (!m_busy) begin
      best = -1;
      for (int k = N-1; k >= 0; k--) if (ireqs[(m_ptr+k)%N].valid) best = (m_ptr+k)%N;
      if (best >= 0) begin
        m_busy = 1;
        m_owner = best;
        m_beat = 0;
      end
    end else if (done) begin
      m_busy = 0;
      m_ptr = (o+1)%N;
      dcyc.push_back(cyc-1);
    end else if (oresp.ready) m_beat++;
    if (done && !reset) begin
      ireqs[o] = (left[o] > 0 || $urandom_range(1, 100) <= rerq_pct) ? rnd_req(o) : '0;
      if (left[o] > 0) left[o]--;
    end
    for (int i = 0; i < N; i++)
      if (!ireqs[i].valid && $urandom_range(1, 100) <= raise_pct) ireqs[i] = rnd_req(i);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((m_busy || any_valid()) && n < maxc) begin
      step();
      n++;
    end
    check("drain_timeout", 128'(m_busy || any_valid()), 128'(0));
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    dcyc.delete();
    d_beats = 0;
    d_lasts = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ireqs[i] = '0;
      left[i] = 0;
    end
    oresp = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_oreq", 128'(oreq), 128'(0));
    check("rst_state", 128'(dut.state), 128'(0));
    check("rst_ptr", 128'(dut.ptr), 128'(0));
    // single DCache MLEN16 read
    clear_logs();
    ireqs[1] = mk(1'b0, 32'h8000_0040, MLEN16, 8'h00);
    step();
    check("single_addr", 128'(oreq.addr), 128'(32'h8000_0040));
    drain(100);
    check("single_beats", 128'(d_beats), 128'(16));
    check("single_last", 128'(d_lasts), 128'(1));
    check("single_idle", 128'(oreq.valid), 128'(0));
    // simultaneous ICache and DCache
    clear_logs();
    ireqs[0] = mk(1'b0, 32'h0000_1000, MLEN4, 8'h00);
    ireqs[1] = mk(1'b0, 32'h8000_2000, MLEN4, 8'h00);
    drain(100);
    check("simul_n", 128'(glog.size()), 128'(2));
    if (glog.size() == 2 && dcyc.size() >= 1) begin
      check("simul_first", 128'(glog[0]), 128'(0));
      check("simul_second", 128'(glog[1]), 128'(1));
      check("simul_bubble", 128'(gcyc[1] - dcyc[0]), 128'(2));
    end
    check("simul_ptr", 128'(dut.ptr), 128'(0));
    // fairness: four bursts each, continuously re-requested
    clear_logs();
    left[0] = 3;
    left[1] = 3;
    ireqs[0] = rnd_req(0);
    ireqs[1] = rnd_req(1);
    drain(1000);
    check("fair_n", 128'(glog.size()), 128'(8));
    for (int k = 0; k < glog.size(); k++) check($sformatf("fair_%0d", k), 128'(glog[k]), 128'(k%2));
    // late arrival of DCache during an ICache burst
    clear_logs();
    ireqs[0] = mk(1'b0, 32'h0000_3000, MLEN8, 8'h00);
    step();
    step();
    step();
    ireqs[1] = mk(1'b0, 32'h8000_4000, MLEN4, 8'h00);
    drain(100);
    check("late_n", 128'(glog.size()), 128'(2));
    if (glog.size() == 2 && dcyc.size() >= 1) begin
      check("late_order", 128'(glog[1]), 128'(1));
      check("late_grant", 128'(gcyc[1] - dcyc[0]), 128'(2));
    end
    // skip path single-beat write
    clear_logs();
    ireqs[1] = mk(1'b1, 32'h1000_0000, MLEN1, 8'h0F);
    step();
    check("skip_write", 128'(oreq.is_write), 128'(1));
    check("skip_strobe", 128'(oreq.strobe), 128'(8'h0F));
    drain(20);
    check("skip_last", 128'(d_lasts), 128'(1));
    check("skip_idle", 128'(oreq.valid), 128'(0));
    // reset on beat 5 of a 16-beat read
    ireqs[0] = mk(1'b0, 32'h0000_5000, MLEN16, 8'h00);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    check("rmid_oreq", 128'(oreq), 128'(0));
    check("rmid_iresp0", 128'(iresps[0]), 128'(0));
    check("rmid_iresp1", 128'(iresps[1]), 128'(0));
    check("rmid_state", 128'(dut.state), 128'(0));
    check("rmid_ptr", 128'(dut.ptr), 128'(0));
    ireqs[0] = '0;
    reset = 1'b0;
    step();
    // randomized traffic
    rnd_mem = 1;
    rerq_pct = 50;
    raise_pct = 20;
    for (int k = 0; k < 3000; k++) step();
    rerq_pct = 0;
    raise_pct = 0;
    drain(500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Arbitrates the single cache-bus (cbus) port between multiple cbus masters (ICache, DCache, uncached/skip path) and forwards exactly one burst at a time to the memory side. It sits between the cache instances and the cbus-to-AXI bridge. It grants round-robin, holds the grant for a whole burst until `last`, and routes the response back to the granted master only.

## Interface
- `NUM_INPUTS`, default 2: number of cbus masters; 2..8.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`: master requests; index 0 = ICache, 1 = DCache.
- `iresps`  out  `cbus_resp_t [NUM_INPUTS]`: per-master responses.
- `oreq`  out  `cbus_req_t`: request to the memory side.
- `oresp`  in  `cbus_resp_t`: response from the memory side (`ready`, `last`, `data`).

## Operation
- Two states:
  - IDLE: no grant. `oreq` = '0 and every `iresps[i]` = '0.
  - BUSY: grant held by `sel`.
- Registers: `state`, `sel` (`$clog2(NUM_INPUTS)` bits, grant index), `ptr` (same width, round-robin start index).
- IDLE arbitration:
  - Candidates are the `i` with `ireqs[i].valid`.
  - Pick the first candidate scanning `ptr`, `ptr+1`, … modulo `NUM_INPUTS`.
  - If any candidate exists: `sel` <= winner, `state` <= BUSY. Otherwise stay IDLE.
- BUSY forwarding:
  - `oreq` = `ireqs[sel]`, all fields, combinational pass-through.
  - `iresps[sel]` = `oresp`; `iresps[j]` = '0 for every `j` ≠ `sel`.
- Completion:
  - A burst completes when `oresp.ready && oresp.last` in BUSY.
  - Then `state` <= IDLE and `ptr` <= `sel+1` with wrap: `NUM_INPUTS-1` → 0.
  - `len`/`burst` are not interpreted; MLEN1 single-beat and MLEN16 WRAP bursts are handled identically.
- Master protocol, required of masters:
  - Hold `valid` and all request fields stable from raising `valid` until `ready && last`.
  - A master may change address between bursts. The DCache does this on WRITEBACK→LOAD; it re-arbitrates like any new request.
- Protocol violation: granted master drops `valid` in BUSY before `last`.
  - `oreq.valid` follows it to 0, so no new beat is issued.
  - The grant is kept until `ready && last`.
  - An assertion flags it in simulation.
- Non-granted masters see `ready` = `last` = 0 and simply wait.
- Starvation bound: a continuously-valid master is granted within `NUM_INPUTS-1` completed bursts.

## Timing
- Reset:
  - `state` = IDLE, `sel` = 0, `ptr` = 0.
  - `oreq` = '0 and all `iresps` = '0 in the cycle after reset is sampled.
  - Reset mid-burst abandons the burst; no further beats are forwarded.
- Grant latency: a valid request sampled in IDLE at cycle t gives `oreq.valid` = 1 at cycle t+1.
- Turnaround:
  - `ready && last` at cycle u gives IDLE at u+1 (outputs zero).
  - The earliest next grant is at u+2.
  - There is exactly one bubble cycle between bursts.
- Beat timing: `iresps[sel].ready/last/data` are combinational from `oresp`, with zero added latency during BUSY.
- Simultaneous events:
  - If several masters become valid in the same IDLE cycle, the round-robin order decides.
  - A master raising `valid` in the completion cycle u is considered at u+1 with the updated `ptr`.

## Structure
- `cbus_req_t`, `cbus_resp_t` and the MLEN/MSIZE/AXI_BURST constants come from the shared `common` package; none are redefined here.
- Add `localparam` / package typedef `arb_idx_t = logic [$clog2(NUM_INPUTS)-1:0]` in `common` for reuse by future arbiters (uncached MMIO, PTW).
- One natural sub-module: `rr_priority_encoder`.
  - Combinational.
  - Inputs: `valid` vector and `ptr`. Outputs: `found` and `idx`.
  - Implemented as a rotate, then a fixed priority encode, then an un-rotate.
- The FSM, the output mux and the response demux stay in `cbus_arbiter`.

## Test plan
- Single master:
  - DCache requests an MLEN16 read at 0x8000_0040. Memory returns 16 beats with `last` on beat 16.
  - `oreq.addr` = 0x8000_0040 from the cycle after the request.
  - `iresps[1]` receives 16 `ready` beats; `iresps[0]` stays '0.
  - IDLE is reached one cycle after `last`.
- Simultaneous requests after reset:
  - ICache and DCache both valid at cycle 0.
  - ICache (index 0) is granted first and DCache second, with one bubble between.
  - `ptr` = 0 after both bursts complete.
- Fairness:
  - Both masters continuously re-request with 4 bursts each.
  - Grant order is 0,1,0,1,0,1,0,1.
  - No master waits more than one burst.
- Late arrival:
  - DCache raises `valid` during the ICache burst.
  - DCache sees no `ready` until the ICache `last`.
  - DCache is granted at `last`+2 cycles.
- Skip path:
  - DCache MLEN1 write to 0x1000_0000 with `strobe` = 0x0F, with the memory side asserting `ready && last` at cycle 3.
  - `oreq.is_write` = 1 and `strobe` = 0x0F are forwarded.
  - `iresps[1].last` pulses once; IDLE follows at cycle 4.
- Reset mid-burst:
  - Assert `reset` on beat 5 of a 16-beat read.
  - The next cycle has `oreq` = '0 and `iresps` = '0, with `state` = IDLE and `ptr` = 0.
